// File: rtl/ctrl_pkg.sv
// rtl/ctrl_pkg.sv - shared control-word layout for the ID-side packer and the pipeline unpacker
package ctrl_pkg;

   localparam int CTRL_W       = 32;
   localparam int CTRL_USED_W  = 8;

   localparam int REGDST_BIT   = 7;
   localparam int ALUSRC_BIT   = 6;
   localparam int ALUOP_LSB    = 4;
   localparam int MEMWRITE_BIT = 3;
   localparam int MEMREAD_BIT  = 2;
   localparam int MEMTOREG_BIT = 1;
   localparam int REGWRITE_BIT = 0;

   typedef struct packed {
      logic       reg_dst;
      logic       alu_src;
      logic [1:0] alu_op;
      logic       mem_write;
      logic       mem_read;
      logic       mem_to_reg;
      logic       reg_write;
   } ctrl_t;

   typedef struct packed {
      logic  valid;
      ctrl_t c;
   } ex_stage_t;

   typedef struct packed {
      logic valid;
      logic mem_write;
      logic mem_read;
      logic mem_to_reg;
      logic reg_write;
   } mem_stage_t;

   typedef struct packed {
      logic valid;
      logic mem_to_reg;
      logic reg_write;
   } wb_stage_t;

   localparam ctrl_t CTRL_BUBBLE = '0;

   function automatic ctrl_t ctrl_unpack(input logic [CTRL_USED_W-1:0] w);
      ctrl_t c;
      c            = CTRL_BUBBLE;
      c.reg_dst    = w[REGDST_BIT];
      c.alu_src    = w[ALUSRC_BIT];
      c.alu_op     = w[ALUOP_LSB +: 2];
      c.mem_write  = w[MEMWRITE_BIT];
      c.mem_read   = w[MEMREAD_BIT];
      c.mem_to_reg = w[MEMTOREG_BIT];
      c.reg_write  = w[REGWRITE_BIT];
      return c;
   endfunction

   // Encoder side: reserved bits always leave ID as zero.
   function automatic logic [CTRL_W-1:0] ctrl_pack(input ctrl_t c);
      logic [CTRL_W-1:0] w;
      w                  = '0;
      w[REGDST_BIT]      = c.reg_dst;
      w[ALUSRC_BIT]      = c.alu_src;
      w[ALUOP_LSB +: 2]  = c.alu_op;
      w[MEMWRITE_BIT]    = c.mem_write;
      w[MEMREAD_BIT]     = c.mem_read;
      w[MEMTOREG_BIT]    = c.mem_to_reg;
      w[REGWRITE_BIT]    = c.reg_write;
      return w;
   endfunction

endpackage

// File: rtl/control_pipe_unpack_if.sv
// rtl/control_pipe_unpack_if.sv - ID-side control word and hazard inputs feeding the unpacker
interface control_pipe_unpack_if;
   import ctrl_pkg::*;

   logic [CTRL_W-1:0] Control_Signal_i;
   logic              valid_i;
   logic              stall_i;
   logic              flush_i;

   modport master (output Control_Signal_i, valid_i, stall_i, flush_i);
   modport slave  (input  Control_Signal_i, valid_i, stall_i, flush_i);
endinterface

// File: rtl/ctrl_stage_reg.sv
// rtl/ctrl_stage_reg.sv - pipeline stage register with hold and clear-to-bubble (bubble is all zero)
module ctrl_stage_reg #(
   parameter int W = 9
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         hold,
   input  logic         clear,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);

   // hold outranks clear so a flush raised during a stall is dropped
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q <= '0;
      end else if (hold) begin
         q <= q;
      end else if (clear) begin
         q <= '0;
      end else begin
         q <= d;
      end
   end

endmodule

// File: rtl/control_pipe_unpack.sv
// rtl/control_pipe_unpack.sv - ID/EX capture and EX/MEM, MEM/WB carry of the packed control word
// Reserved-bit checking and error counting are built only with CTRL_RSVD_CHECK_EN defined.
module control_pipe_unpack
   import ctrl_pkg::*;
#(
   parameter int ERR_CNT_W = 8
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   control_pipe_unpack_if.slave ctrl,
   output logic                 RegDst_o,
   output logic                 ALUSrc_o,
   output logic [1:0]           ALUOp_o,
   output logic                 ex_valid_o,
   output logic                 MemWrite_o,
   output logic                 MemRead_o,
   output logic                 mem_valid_o,
   output logic                 MemtoReg_o,
   output logic                 RegWrite_o,
   output logic                 wb_valid_o,
   output logic                 rsvd_err_o,
   output logic [ERR_CNT_W-1:0] err_cnt_o
);

   ex_stage_t  id_ex_d,  id_ex_q;
   mem_stage_t ex_mem_d, ex_mem_q;
   wb_stage_t  mem_wb_d, mem_wb_q;
   logic       rsvd_viol;
   logic       id_ex_clear;

`ifdef CTRL_RSVD_CHECK_EN
   logic                 rsvd_err;
   logic [ERR_CNT_W-1:0] err_cnt;
   logic                 count_viol;

   assign rsvd_viol  = ctrl.valid_i && (ctrl.Control_Signal_i[CTRL_W-1:CTRL_USED_W] != '0);
   // Only words that would really be captured are counted; stalled or flushed ones are not.
   assign count_viol = rsvd_viol && !ctrl.stall_i && !ctrl.flush_i;

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         rsvd_err <= 1'b0;
         err_cnt  <= '0;
      end else if (count_viol) begin
         rsvd_err <= 1'b1;
         if (err_cnt != '1) begin
            err_cnt <= err_cnt + ERR_CNT_W'(1);
         end
      end
   end

   assign rsvd_err_o = rsvd_err;
   assign err_cnt_o  = err_cnt;
`else
   wire unused_rsvd = ^ctrl.Control_Signal_i[CTRL_W-1:CTRL_USED_W];

   assign rsvd_viol  = 1'b0;
   assign rsvd_err_o = 1'b0;
   assign err_cnt_o  = '0;
`endif

   assign id_ex_d.valid = 1'b1;
   assign id_ex_d.c     = ctrl_unpack(ctrl.Control_Signal_i[CTRL_USED_W-1:0]);
   assign id_ex_clear   = ctrl.flush_i || !ctrl.valid_i || rsvd_viol;

   ctrl_stage_reg #(.W($bits(ex_stage_t))) u_id_ex (
      .clk   (clk_i),
      .rst_n (rst_i),
      .hold  (ctrl.stall_i),
      .clear (id_ex_clear),
      .d     (id_ex_d),
      .q     (id_ex_q)
   );

   assign ex_mem_d.valid      = id_ex_q.valid;
   assign ex_mem_d.mem_write  = id_ex_q.c.mem_write;
   assign ex_mem_d.mem_read   = id_ex_q.c.mem_read;
   assign ex_mem_d.mem_to_reg = id_ex_q.c.mem_to_reg;
   assign ex_mem_d.reg_write  = id_ex_q.c.reg_write;

   ctrl_stage_reg #(.W($bits(mem_stage_t))) u_ex_mem (
      .clk   (clk_i),
      .rst_n (rst_i),
      .hold  (ctrl.stall_i),
      .clear (1'b0),
      .d     (ex_mem_d),
      .q     (ex_mem_q)
   );

   assign mem_wb_d.valid      = ex_mem_q.valid;
   assign mem_wb_d.mem_to_reg = ex_mem_q.mem_to_reg;
   assign mem_wb_d.reg_write  = ex_mem_q.reg_write;

   ctrl_stage_reg #(.W($bits(wb_stage_t))) u_mem_wb (
      .clk   (clk_i),
      .rst_n (rst_i),
      .hold  (ctrl.stall_i),
      .clear (1'b0),
      .d     (mem_wb_d),
      .q     (mem_wb_q)
   );

   assign RegDst_o    = id_ex_q.c.reg_dst;
   assign ALUSrc_o    = id_ex_q.c.alu_src;
   assign ALUOp_o     = id_ex_q.c.alu_op;
   assign ex_valid_o  = id_ex_q.valid;
   assign MemWrite_o  = ex_mem_q.mem_write;
   assign MemRead_o   = ex_mem_q.mem_read;
   assign mem_valid_o = ex_mem_q.valid;
   assign MemtoReg_o  = mem_wb_q.mem_to_reg;
   assign RegWrite_o  = mem_wb_q.reg_write;
   assign wb_valid_o  = mem_wb_q.valid;

endmodule
